pipe_skid_stage: RTL

//   Receiving end of the stall-enable pipeline register interface: an elastic stage

---
 rtl/pipe_skid_stage.sv | 87 ++++++++
 1 files changed

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage with a main and a skid register. in_ready and out_valid
// are decoded only from the state register, so no ready path runs through the stage.
module pipe_skid_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    // The state encoding equals the entry count, so occupancy also exposes the FSM state.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    // Handshake: a word moves on a clock edge only when valid and ready are both high
    // in the cycle before that edge. Valid must not depend on ready. Ready must not
    // depend on valid.
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             accept;
    logic             pop;

    assign in_ready  = (state_q != ST_SKID);
    assign out_valid = (state_q != ST_EMPTY);
    assign occupancy = state_q;
    assign out_data  = main_q;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && pop) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = ST_SKID;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule
